// File: rtl/round_checker_pkg.sv
// Shared types and challenge-word field map for the round checker.
package round_checker_pkg;

  // Round type carried in the top two bits of each challenge word
  typedef enum logic [1:0] {
    BOTAO       = 2'b00,
    BOTAO_SERVO = 2'b01,
    SERVO       = 2'b10,
    SENSOR      = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_INPUT,
    CHECK,
    RESULT,
    DONE
  } state_e;

  // Bit positions inside the 60-bit challenge word
  localparam int unsigned OPCODE_HI   = 59;
  localparam int unsigned OPCODE_LO   = 58;
  localparam int unsigned LEDS_HI     = 57;
  localparam int unsigned LEDS_LO     = 54;
  localparam int unsigned POS_HI      = 53;
  localparam int unsigned POS_LO      = 52;
  localparam int unsigned LIM_INF_HI  = 51;
  localparam int unsigned LIM_INF_LO  = 40;
  localparam int unsigned LIM_SUP_HI  = 39;
  localparam int unsigned LIM_SUP_LO  = 28;
  localparam int unsigned EXPECTED_HI = 27;
  localparam int unsigned EXPECTED_LO = 0;
  localparam int unsigned CHAR_W      = 7;

  // Expected character for a given position; position 0 sits in the top bits
  function automatic logic [CHAR_W-1:0] expected_char(input logic [27:0] exp,
                                                      input logic [1:0]  idx);
    logic [CHAR_W-1:0] c;
    case (idx)
      2'd0:    c = exp[27:21];
      2'd1:    c = exp[20:14];
      2'd2:    c = exp[13:7];
      default: c = exp[6:0];
    endcase
    return c;
  endfunction

  // Inclusive window test; BCD readings order correctly as plain unsigned values
  function automatic logic in_range(input logic [11:0] d,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/round_checker_char_collector.sv
// Collects the four answer characters of a round and tracks per-position matches.
module char_collector
  import round_checker_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        char_valid,
  input  logic [6:0]  char_data,
  input  logic [27:0] expected,
  output logic        complete,
  output logic        all_match
);

  logic [1:0] idx;
  logic [3:0] match;

  // Record whether each accepted character equals its expected slot
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx   <= '0;
      match <= '0;
    end else if (char_valid) begin
      match[idx] <= (char_data == expected_char(expected, idx));
      idx        <= idx + 2'd1;
    end
  end

  // The fourth character is being accepted this cycle; match flags settle at this edge
  assign complete  = char_valid && (idx == 2'd3);
  assign all_match = &match;

endmodule

// File: rtl/round_checker.sv
// Round checker: steps through NUM_ROUNDS challenges, judges each answer
// (four typed characters or one distance reading) and keeps the score.
// Optional per-round timeout enabled by defining ROUND_CHECKER_TIMEOUT_EN.
module round_checker
  import round_checker_pkg::*;
#(
  parameter int NUM_ROUNDS     = 8,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  output logic [2:0]  address,
  input  logic [59:0] challenge,
  input  logic        char_valid,
  input  logic [6:0]  char_data,
  input  logic        dist_valid,
  input  logic [11:0] distance,
  output logic [3:0]  leds,
  output logic [1:0]  servo_pos,
  output logic        hit,
  output logic        miss,
  output logic [3:0]  score,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST_ADDR = 3'(NUM_ROUNDS - 1);

  state_e      state;
  opcode_e     opcode_q;
  logic [11:0] lim_inf_q;
  logic [11:0] lim_sup_q;
  logic [11:0] dist_q;
  logic [27:0] expected_q;

  logic in_wait;
  logic is_sensor;
  logic char_strobe;
  logic complete;
  logic all_match;
  logic verdict;
  logic tmo_hit;

  assign in_wait     = (state == WAIT_INPUT);
  assign is_sensor   = (opcode_q == SENSOR);
  assign char_strobe = in_wait && !is_sensor && char_valid;
  assign verdict     = is_sensor ? in_range(dist_q, lim_inf_q, lim_sup_q) : all_match;

  char_collector u_collector (
    .clock      (clock),
    .reset      (reset),
    .clear      (state == LOAD),
    .char_valid (char_strobe),
    .char_data  (char_data),
    .expected   (expected_q),
    .complete   (complete),
    .all_match  (all_match)
  );

`ifdef ROUND_CHECKER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;

  // Count cycles spent waiting for an answer; restarted for every round
  always_ff @(posedge clock) begin
    if (reset || state == LOAD) begin
      tmo_cnt <= '0;
    end else if (in_wait) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_wait && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Game sequencer with registered outputs; hit/miss are high for the RESULT cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      score      <= '0;
      leds       <= '0;
      servo_pos  <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      opcode_q   <= BOTAO;
      lim_inf_q  <= '0;
      lim_sup_q  <= '0;
      dist_q     <= '0;
      expected_q <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (iniciar) begin
            score   <= '0;
            address <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          opcode_q   <= opcode_e'(challenge[OPCODE_HI:OPCODE_LO]);
          leds       <= challenge[LEDS_HI:LEDS_LO];
          servo_pos  <= challenge[POS_HI:POS_LO];
          lim_inf_q  <= challenge[LIM_INF_HI:LIM_INF_LO];
          lim_sup_q  <= challenge[LIM_SUP_HI:LIM_SUP_LO];
          expected_q <= challenge[EXPECTED_HI:EXPECTED_LO];
          state      <= WAIT_INPUT;
        end
        WAIT_INPUT: begin
          // A completed answer wins over a timeout landing in the same cycle
          if (is_sensor && dist_valid) begin
            dist_q <= distance;
            state  <= CHECK;
          end else if (!is_sensor && complete) begin
            state <= CHECK;
          end else if (tmo_hit) begin
            miss  <= 1'b1;
            state <= RESULT;
          end
        end
        CHECK: begin
          hit   <= verdict;
          miss  <= !verdict;
          state <= RESULT;
        end
        RESULT: begin
          if (hit && score != 4'hF) begin
            score <= score + 4'd1;
          end
          if (address == LAST_ADDR) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            leds  <= '0;
            state <= DONE;
          end else begin
            address <= address + 3'd1;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_checker.sv
// Self-checking bench for round_checker: directed games plus randomized rounds
// judged by a behavioural model of the scoring rules.
module tb_round_checker;

  localparam int NR  = 8;
  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [2:0]  address;
  logic [59:0] challenge;
  logic        char_valid;
  logic [6:0]  char_data;
  logic        dist_valid;
  logic [11:0] distance;
  logic [3:0]  leds;
  logic [1:0]  servo_pos;
  logic        hit;
  logic        miss;
  logic [3:0]  score;
  logic        busy;
  logic        done;

  logic [59:0] rom        [NR];
  logic [27:0] plan_chars [NR];
  logic [11:0] plan_dist  [NR];

  int compared   = 0;
  int mismatched = 0;
  int model_score;

  always #5 clock = ~clock;

  assign challenge = rom[address];

  round_checker #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .address    (address),
    .challenge  (challenge),
    .char_valid (char_valid),
    .char_data  (char_data),
    .dist_valid (dist_valid),
    .distance   (distance),
    .leds       (leds),
    .servo_pos  (servo_pos),
    .hit        (hit),
    .miss       (miss),
    .score      (score),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] mk(input logic [1:0] opc, input logic [3:0] l, input logic [1:0] p,
                                     input logic [11:0] inf, input logic [11:0] sup, input logic [27:0] e);
    return {opc, l, p, inf, sup, e};
  endfunction

  function automatic logic [27:0] pack4(input byte a, input byte b, input byte c, input byte d);
    return {a[6:0], b[6:0], c[6:0], d[6:0]};
  endfunction

  function automatic logic [11:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  function automatic logic [6:0] rand_char();
    return 7'($urandom_range(33, 126));
  endfunction

  // Random challenge plus a planned answer that hits or misses about half the time
  task automatic rand_round(input int r);
    logic [11:0] lo, hi, t;
    logic [27:0] e, c;
    int j;
    lo = rand_bcd();
    hi = rand_bcd();
    if (lo > hi) begin t = lo; lo = hi; hi = t; end
    e = {rand_char(), rand_char(), rand_char(), rand_char()};
    c = e;
    if ($urandom_range(0, 1) == 1) begin
      j = $urandom_range(0, 3);
      c[7*j +: 7] = c[7*j +: 7] ^ 7'h01;
    end
    rom[r] = mk(2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), lo, hi, e);
    plan_chars[r] = c;
    case ($urandom_range(0, 2))
      0:       plan_dist[r] = lo;
      1:       plan_dist[r] = hi;
      default: plan_dist[r] = rand_bcd();
    endcase
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/address"},   address,   0);
    check({tag, "/score"},     score,     0);
    check({tag, "/leds"},      leds,      0);
    check({tag, "/servo_pos"}, servo_pos, 0);
    check({tag, "/hit"},       hit,       0);
    check({tag, "/miss"},      miss,      0);
    check({tag, "/busy"},      busy,      0);
    check({tag, "/done"},      done,      0);
  endtask

  // From IDLE or DONE: request a game; returns at the first WAIT_INPUT cycle
  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    model_score = 0;
    check("start/address", address, 0);
    check("start/score",   score,   0);
    check("start/busy",    busy,    1);
    check("start/done",    done,    0);
    tick();
  endtask

  // Play round r from its first WAIT_INPUT cycle through its RESULT cycle
  task automatic play_round(input int r);
    logic [59:0] w;
    logic        exp_hit;
    int          n;
    w = rom[r];
    check("round/leds",      leds,      w[57:54]);
    check("round/servo_pos", servo_pos, w[53:52]);
    check("round/busy",      busy,      1);
    check("round/address",   address,   64'(r));
    if (w[59:58] != 2'b11) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) begin
          dist_valid = 1'($urandom_range(0, 1));
          distance   = rand_bcd();
          iniciar    = 1'($urandom_range(0, 1));
          tick();
          dist_valid = 1'b0;
          iniciar    = 1'b0;
        end
        char_valid = 1'b1;
        char_data  = plan_chars[r][27-7*k -: 7];
        dist_valid = 1'($urandom_range(0, 1));
        distance   = rand_bcd();
        tick();
        char_valid = 1'b0;
        dist_valid = 1'b0;
      end
      exp_hit = (plan_chars[r] == w[27:0]);
    end else begin
      repeat ($urandom_range(0, 3)) begin
        char_valid = 1'b1;
        char_data  = rand_char();
        iniciar    = 1'($urandom_range(0, 1));
        tick();
        char_valid = 1'b0;
        iniciar    = 1'b0;
      end
      dist_valid = 1'b1;
      distance   = plan_dist[r];
      char_valid = 1'($urandom_range(0, 1));
      char_data  = rand_char();
      tick();
      dist_valid = 1'b0;
      char_valid = 1'b0;
      exp_hit = (plan_dist[r] >= w[51:40]) && (plan_dist[r] <= w[39:28]);
    end
    n = 0;
    while (!(hit || miss) && n < 4) begin
      tick();
      n++;
    end
    check("result/hit",  hit,  exp_hit);
    check("result/miss", miss, !exp_hit);
    if (exp_hit && model_score < 15) model_score++;
    tick();
    check("after/pulses", {hit, miss}, 0);
    check("after/score",  score, 64'(model_score));
    if (r == NR - 1) begin
      check("last/address", address, 64'(r));
      check("last/done",    done,    1);
      check("last/busy",    busy,    0);
      check("last/leds",    leds,    0);
    end else begin
      check("next/address", address, 64'(r + 1));
      check("next/busy",    busy,    1);
      tick();
    end
  endtask

  initial begin
    int n;
    int pulses;
    reset      = 1'b1;
    iniciar    = 1'b0;
    char_valid = 1'b0;
    char_data  = '0;
    dist_valid = 1'b0;
    distance   = '0;
    for (int i = 0; i < NR; i++) rand_round(i);
    repeat (3) tick();
    check_cleared("reset");
    reset = 1'b0;
    tick();
    check("idle/busy", busy, 0);

    // Game 1: directed character and sensor boundary rounds
    rom[0] = mk(2'b00, 4'hA, 2'd1, 12'h000, 12'h000, pack4("A", "$", "0", "#"));
    plan_chars[0] = pack4("A", "$", "0", "#");
    rom[1] = mk(2'b01, 4'h5, 2'd2, 12'h000, 12'h000, pack4("B", "$", "1", "#"));
    plan_chars[1] = pack4("B", "$", "2", "#");
    for (int i = 2; i < 6; i++) rom[i] = mk(2'b11, 4'(i), 2'd3, 12'h070, 12'h080, 28'h0);
    plan_dist[2] = 12'h070;
    plan_dist[3] = 12'h080;
    plan_dist[4] = 12'h081;
    plan_dist[5] = 12'h069;
    start_game();
    for (int r = 0; r < NR; r++) play_round(r);
    tick();
    check("done_hold/done",    done,    1);
    check("done_hold/address", address, 7);
    check("done_hold/score",   score,   64'(model_score));

    // Game 2: restart from DONE, reset partway through round 3
    for (int i = 0; i < NR; i++) rand_round(i);
    rom[3][59:58] = 2'b00;
    start_game();
    for (int r = 0; r < 3; r++) play_round(r);
    for (int k = 0; k < 2; k++) begin
      char_valid = 1'b1;
      char_data  = plan_chars[3][27-7*k -: 7];
      tick();
      char_valid = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cleared("midreset");
    char_valid = 1'b1;
    char_data  = rand_char();
    tick();
    char_valid = 1'b0;
    tick();
    check_cleared("idle_after_reset");

    // Game 3: fully random challenge table
    for (int i = 0; i < NR; i++) rand_round(i);
    start_game();
    for (int r = 0; r < NR; r++) play_round(r);

    // Silent round: timeout behaviour depends on build configuration
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rom[0][59:58] = 2'b00;
    start_game();
`ifdef ROUND_CHECKER_TIMEOUT_EN
    n = 0;
    while (!(hit || miss) && n < 1100) begin
      tick();
      n++;
    end
    check("timeout/cycles", 64'(n), 100);
    check("timeout/miss",   miss,   1);
    check("timeout/hit",    hit,    0);
    tick();
    check("timeout/score",   score,   0);
    check("timeout/address", address, 1);
`else
    pulses = 0;
    n = 0;
    repeat (1000) begin
      tick();
      if (hit || miss) pulses++;
    end
    check("no_timeout/pulses",  64'(pulses), 0);
    check("no_timeout/busy",    busy,        1);
    check("no_timeout/address", address,     0);
    check("no_timeout/count",   64'(n),      0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
